// File: rtl/instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode
// Description : Encodes RV32I instruction fields into 32-bit machine words.
//               Each word is pushed into a 2-entry FIFO and then written to
//               instruction memory at sequential byte addresses, starting at
//               BASE_ADDR and advancing by 4 per write.
//               Optional macro ENC_RANGE_CHK_EN adds an immediate
//               representability check that raises err.
// Ports       : clk, rst_n            - clock, async active-low reset
//               clr                   - sync clear of FIFO/address/count/err
//               in_valid / in_ready   - field-set handshake
//               opcode, funct3, funct7,
//               regs_rd/rs1/rs2, imme - instruction fields (imm unencoded)
//               mem_we / mem_ready    - memory write handshake
//               mem_addr, mem_wdata   - write address and encoded word
//               instr_cnt             - words written (mod 2^16)
//               err                   - sticky error flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        regs_rd,
    input  logic [4:0]        regs_rs1,
    input  logic [4:0]        regs_rs2,
    input  logic [31:0]       imme,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       instr_cnt,
    output logic              err
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);

    logic [31:0]       w_enc;
    logic              w_unknown;
    logic              w_range_err;
    logic              w_push;
    logic              w_pop;

    logic [31:0]       r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cnt;
    logic              r_err;

    // Format selection; unknown opcodes fall back to the R layout.
    always_comb begin
        w_enc     = {funct7, regs_rs2, regs_rs1, funct3, regs_rd, opcode};
        w_unknown = 1'b0;
        case (opcode)
            c_OP_R: ;
            c_OP_IMM, c_OP_LOAD, c_OP_JALR:
                w_enc = {imme[11:0], regs_rs1, funct3, regs_rd, opcode};
            c_OP_STORE:
                w_enc = {imme[11:5], regs_rs2, regs_rs1, funct3, imme[4:0], opcode};
            c_OP_BRANCH:
                w_enc = {imme[12], imme[10:5], regs_rs2, regs_rs1, funct3,
                         imme[4:1], imme[11], opcode};
            c_OP_LUI, c_OP_AUIPC:
                w_enc = {imme[31:12], regs_rd, opcode};
            c_OP_JAL:
                w_enc = {imme[20], imme[10:1], imme[11], imme[19:12], regs_rd, opcode};
            default:
                w_unknown = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHK_EN
    // Immediate must sign-extend from its encoded width; branch/jump
    // offsets must also be even since bit 0 is not encoded.
    always_comb begin
        w_range_err = 1'b0;
        case (opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_STORE:
                w_range_err = !((&imme[31:11]) || !(|imme[31:11]));
            c_OP_BRANCH:
                w_range_err = !((&imme[31:12]) || !(|imme[31:12])) || imme[0];
            c_OP_JAL:
                w_range_err = !((&imme[31:20]) || !(|imme[31:20])) || imme[0];
            c_OP_LUI, c_OP_AUIPC:
                w_range_err = |imme[11:0];
            default:
                w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    // in_ready depends only on registered occupancy, never on mem_ready.
    assign in_ready  = (r_count != 2'd2);
    assign mem_we    = (r_count != 2'd0);
    assign mem_wdata = mem_we ? r_mem[r_rptr] : 32'h0;
    assign mem_addr  = r_addr;
    assign instr_cnt = r_cnt;
    assign err       = r_err;

    assign w_push = in_valid & in_ready;
    assign w_pop  = mem_we & mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 32'h0;
            r_mem[1] <= 32'h0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_addr   <= BASE_ADDR;
            r_cnt    <= 16'h0;
            r_err    <= 1'b0;
        end else if (clr) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_addr  <= BASE_ADDR;
            r_cnt   <= 16'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_enc;
                r_wptr        <= ~r_wptr;
                if (w_unknown || w_range_err) begin
                    r_err <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
                r_addr <= r_addr + c_ADDR_STEP;
                r_cnt  <= r_cnt + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encode
// Description : Directed self-checking bench for instr_encode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encode;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        regs_rd;
    logic [4:0]        regs_rs1;
    logic [4:0]        regs_rs2;
    logic [31:0]       imme;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       instr_cnt;
    logic              err;

    int checks = 0;
    int errors = 0;

`ifdef ENC_RANGE_CHK_EN
    localparam logic c_RANGE_ON = 1'b1;
`else
    localparam logic c_RANGE_ON = 1'b0;
`endif

    logic [ADDR_W-1:0] got_addr [$];
    logic [31:0]       got_data [$];

    instr_encode #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .regs_rd   (regs_rd),
        .regs_rs1  (regs_rs1),
        .regs_rs2  (regs_rs2),
        .imme      (imme),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .instr_cnt (instr_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so the values seen
    // at the falling edge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (rst_n && !clr && mem_we && mem_ready) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        regs_rd  = rd;
        regs_rs1 = rs1;
        regs_rs2 = rs2;
        imme     = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int n = 0;
        drive(op, f3, f7, rd, rs1, rs2, imm);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b1 || mem_wdata !== 32'h0 ||
            mem_addr !== 12'h0 || instr_cnt !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: we=%0b rdy=%0b wdata=%h addr=%h cnt=%0d err=%0b required 0 1 0 0 0 0",
                     mem_we, in_ready, mem_wdata, mem_addr, instr_cnt, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        mem_ready = 1'b1;
        do_clr();
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h00500093 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL latency: we=%0b wdata=%h addr=%h required 1 00500093 000",
                     mem_we, mem_wdata, mem_addr);
        end
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != 2 || instr_cnt !== 16'd2 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL seq_count: writes=%0d cnt=%0d we=%0b required 2 2 0",
                     got_data.size(), instr_cnt, mem_we);
        end else begin
            checks++;
            if (got_data[0] !== 32'h00500093 || got_addr[0] !== 12'h000 ||
                got_data[1] !== 32'h002081B3 || got_addr[1] !== 12'h004) begin
                errors++;
                $display("FAIL seq_words: got %h@%h %h@%h required 00500093@000 002081b3@004",
                         got_data[0], got_addr[0], got_data[1], got_addr[1]);
            end
        end
    endtask

    task automatic test_formats();
        logic [31:0] exp [4];
        exp[0] = 32'h0020A423;
        exp[1] = 32'hFE208EE3;
        exp[2] = 32'h001000EF;
        exp[3] = 32'h123452B7;
        mem_ready = 1'b1;
        do_clr();
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != 4) begin
            errors++;
            $display("FAIL fmt_count: writes=%0d required 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== exp[i] || got_addr[i] !== 12'(4 * i)) begin
                    errors++;
                    $display("FAIL fmt_word%0d: got %h@%h required %h@%h",
                             i, got_data[i], got_addr[i], exp[i], 12'(4 * i));
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err: err=%0b required 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        mem_ready = 1'b0;
        do_clr();
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        @(posedge clk);
        #1;
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: in_ready=%0b required 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mem_we !== 1'b1 || mem_wdata !== 32'h00100093 || mem_addr !== 12'h000 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall%0d: we=%0b wdata=%h addr=%h rdy=%0b required 1 00100093 000 0",
                         i, mem_we, mem_wdata, mem_addr, in_ready);
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d required 3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_addr[i] !== 12'(4 * i) || got_data[i] !== (32'h00000093 | (32'(i + 1) << 20))) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got %h@%h required %h@%h", i, got_data[i], got_addr[i],
                             32'h00000093 | (32'(i + 1) << 20), 12'(4 * i));
                end
            end
        end
    endtask

    task automatic test_error();
        mem_ready = 1'b1;
        do_clr();
        send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%0b required 1", err);
        end
        for (int i = 0; i < 10; i++) begin
            send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i));
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || instr_cnt !== 16'd11 || got_data.size() != 11) begin
            errors++;
            $display("FAIL err_sticky: err=%0b cnt=%0d writes=%0d required 1 11 11",
                     err, instr_cnt, got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'h0000007F || got_addr[0] !== 12'h000) begin
                errors++;
                $display("FAIL err_word: got %h@%h required 0000007f@000", got_data[0], got_addr[0]);
            end
        end
        do_clr();
        checks++;
        if (err !== 1'b0 || mem_addr !== 12'h000 || instr_cnt !== 16'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%0b addr=%h cnt=%0d we=%0b required 0 000 0 0",
                     err, mem_addr, instr_cnt, mem_we);
        end
    endtask

    task automatic test_clr_priority();
        mem_ready = 1'b0;
        do_clr();
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        drive(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid  = 1'b1;
        mem_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0 || instr_cnt !== 16'd0 || mem_addr !== 12'h000 ||
            err !== 1'b0 || got_data.size() != 0) begin
            errors++;
            $display("FAIL clr_priority: we=%0b cnt=%0d addr=%h err=%0b writes=%0d required 0 0 000 0 0",
                     mem_we, instr_cnt, mem_addr, err, got_data.size());
        end
    endtask

    task automatic test_range();
        mem_ready = 1'b1;
        do_clr();
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'h80000093 || err !== c_RANGE_ON) begin
            errors++;
            $display("FAIL range_addi: writes=%0d word=%h err=%0b required 1 80000093 %0b",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, err, c_RANGE_ON);
        end
        do_clr();
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 32'h123452B7 || err !== c_RANGE_ON) begin
            errors++;
            $display("FAIL range_lui: writes=%0d word=%h err=%0b required 1 123452b7 %0b",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, err, c_RANGE_ON);
        end
    endtask

    task automatic test_reset_pending();
        mem_ready = 1'b0;
        do_clr();
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b1 || mem_wdata !== 32'h0 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL rst_async: we=%0b rdy=%0b wdata=%h addr=%h required 0 1 0 000",
                     mem_we, in_ready, mem_wdata, mem_addr);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        got_addr.delete();
        got_data.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b0 || got_data.size() != 0 || instr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_discard: we=%0b writes=%0d cnt=%0d required 0 0 0",
                     mem_we, got_data.size(), instr_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h00500093 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL rst_first_accept: we=%0b wdata=%h addr=%h required 1 00500093 000",
                     mem_we, mem_wdata, mem_addr);
        end
    endtask

    task automatic test_wrap();
        mem_ready = 1'b1;
        do_clr();
        for (int i = 0; i < 1024; i++) begin
            send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_addr !== 12'h000 || instr_cnt !== 16'd1024 || got_data.size() != 1024) begin
            errors++;
            $display("FAIL addr_wrap: addr=%h cnt=%0d writes=%0d required 000 1024 1024",
                     mem_addr, instr_cnt, got_data.size());
        end else begin
            checks++;
            if (got_addr[1023] !== 12'hFFC) begin
                errors++;
                $display("FAIL addr_last: got %h required ffc", got_addr[1023]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        test_reset();
        test_sequence();
        test_formats();
        test_back_to_back();
        test_error();
        test_clr_priority();
        test_range();
        test_reset_pending();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
